u409_cia_cycle: RTL and testbench

//  Responder for 68040 bus cycles decoded as CIA space by the address decoder.

---
 rtl/u409_cia_cycle.sv | 91 +++++++++
 tb/tb_u409_cia_cycle.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/u409_cia_cycle.sv
// CIA-space bus cycle responder: free-running E clock generator plus a small FSM
// that aligns each CIA access to one full E period and acknowledges with TAn.
module u409_cia_cycle #(
   parameter int unsigned E_LOW  = 34,
   parameter int unsigned E_HIGH = 22
) (
   input  logic CLK40,
   input  logic RESET,
   input  logic TSn,
   input  logic CIA_SPACE,
   input  logic RnW,
   output logic E,
   output logic CIA_ENABLE,
   output logic DATA_LE,
   output logic DATA_OE,
   output logic TAn
);

   localparam int unsigned E_PERIOD = E_LOW + E_HIGH;
   localparam logic [5:0]  ECNT_LAST = 6'(E_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, TERM} state_t;

   state_t     state_q, state_d;
   logic [5:0] ecnt_q, ecnt_d;
   logic       rnw_q, rnw_d;
   logic       e_q, e_d;
   logic       cia_enable_q, cia_enable_d;
   logic       data_le_q, data_le_d;
   logic       data_oe_q, data_oe_d;
   logic       tan_q, tan_d;
   logic       last;
   logic       req;

   assign last = (ecnt_q == ECNT_LAST);
   assign req  = !TSn && CIA_SPACE;

   // Outputs are derived from next-state values so each registered output
   // is valid in exactly the cycle its state is occupied.
   always_comb begin
      ecnt_d  = last ? '0 : ecnt_q + 6'd1;
      e_d     = (ecnt_d >= 6'(E_LOW));
      state_d = state_q;
      rnw_d   = rnw_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               rnw_d   = RnW;
               state_d = last ? ACTIVE : SYNC;
            end
         end
         SYNC:    if (last) state_d = ACTIVE;
         ACTIVE:  if (last) state_d = TERM;
         TERM:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      cia_enable_d = (state_d == ACTIVE);
      data_oe_d    = (state_d == ACTIVE) && !rnw_d;
      data_le_d    = (state_d == ACTIVE) && rnw_d && (ecnt_d == ECNT_LAST);
      tan_d        = (state_d != TERM);
   end

   always_ff @(posedge CLK40) begin
      if (RESET) begin
         state_q      <= IDLE;
         ecnt_q       <= '0;
         rnw_q        <= 1'b1;
         e_q          <= 1'b0;
         cia_enable_q <= 1'b0;
         data_le_q    <= 1'b0;
         data_oe_q    <= 1'b0;
         tan_q        <= 1'b1;
      end else begin
         state_q      <= state_d;
         ecnt_q       <= ecnt_d;
         rnw_q        <= rnw_d;
         e_q          <= e_d;
         cia_enable_q <= cia_enable_d;
         data_le_q    <= data_le_d;
         data_oe_q    <= data_oe_d;
         tan_q        <= tan_d;
      end
   end

   assign E          = e_q;
   assign CIA_ENABLE = cia_enable_q;
   assign DATA_LE    = data_le_q;
   assign DATA_OE    = data_oe_q;
   assign TAn        = tan_q;

endmodule

// File: tb/tb_u409_cia_cycle.sv
// Scoreboard bench for u409_cia_cycle: stimulus pushes expected transactions,
// a negedge monitor checks E, CIA_ENABLE, DATA_OE, DATA_LE and TAn every cycle.
module tb_u409_cia_cycle;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tsn = 1'b1;
   logic cia_space = 1'b0;
   logic rnw = 1'b1;
   logic e, cia_enable, data_le, data_oe, tan;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned cyc = 0;
   int unsigned mcnt = 0;
   bit          mon_en = 1'b0;

   typedef struct {
      int unsigned tan;
      bit          rd;
   } txn_t;
   txn_t sb[$];

   u409_cia_cycle #(.E_LOW(34), .E_HIGH(22)) dut (
      .CLK40     (clk),
      .RESET     (rst),
      .TSn       (tsn),
      .CIA_SPACE (cia_space),
      .RnW       (rnw),
      .E         (e),
      .CIA_ENABLE(cia_enable),
      .DATA_LE   (data_le),
      .DATA_OE   (data_oe),
      .TAn       (tan)
   );

   always #12.5 clk = ~clk;

   // Reference E counter: reset to 0, wraps after 56 clocks.
   always @(posedge clk) begin
      cyc  <= cyc + 1;
      mcnt <= rst ? 0 : ((mcnt == 55) ? 0 : mcnt + 1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         logic exp_en, exp_oe, exp_le, exp_tan;
         exp_en = 1'b0; exp_oe = 1'b0; exp_le = 1'b0; exp_tan = 1'b1;
         if (sb.size() > 0) begin
            exp_en  = (cyc >= sb[0].tan - 56) && (cyc <= sb[0].tan - 1);
            exp_oe  = exp_en && !sb[0].rd;
            exp_le  = sb[0].rd && (cyc == sb[0].tan - 1);
            exp_tan = (cyc != sb[0].tan);
         end
         chk("E", {31'd0, e}, {31'd0, (mcnt >= 34)});
         chk("CIA_ENABLE", {31'd0, cia_enable}, {31'd0, exp_en});
         chk("DATA_OE", {31'd0, data_oe}, {31'd0, exp_oe});
         chk("DATA_LE", {31'd0, data_le}, {31'd0, exp_le});
         chk("TAn", {31'd0, tan}, {31'd0, exp_tan});
         if (sb.size() > 0 && cyc == sb[0].tan) void'(sb.pop_front());
         // Reset sampled at the coming edge aborts any access without TAn.
         if (rst) sb.delete();
      end
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int unsigned n);
      while (cyc < n) next_cyc();
   endtask

   // Issue a request in the current cycle (DUT must be idle); TAn expected
   // 112 - ecnt clocks later, where ecnt is the counter value when sampled.
   task automatic issue_now(input bit rd, output int unsigned tan_cyc);
      txn_t t;
      tan_cyc  = cyc + 112 - mcnt;
      t.tan    = tan_cyc;
      t.rd     = rd;
      sb.push_back(t);
      tsn = 1'b0; cia_space = 1'b1; rnw = rd;
      next_cyc();
      tsn = 1'b1; cia_space = 1'b0; rnw = 1'b1;
   endtask

   task automatic issue_at(input bit rd, input int unsigned target, output int unsigned tan_cyc);
      int unsigned n = 0;
      next_cyc();
      while (mcnt != target && n < 60) begin
         next_cyc();
         n++;
      end
      if (mcnt != target) chk("align_timeout", mcnt, target);
      issue_now(rd, tan_cyc);
   endtask

   task automatic drain();
      int unsigned n = 0;
      while (sb.size() != 0 && n < 300) begin
         next_cyc();
         n++;
      end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
   endtask

   task automatic pulse_ts(input bit space);
      tsn = 1'b0; cia_space = space; rnw = 1'b0;
      next_cyc();
      tsn = 1'b1; cia_space = 1'b0; rnw = 1'b1;
   endtask

   initial begin
      int unsigned t1, t2;
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      // Free run across several E periods including wraps.
      repeat (130) next_cyc();

      // Read sampled at LAST: 57 clocks to TAn, DATA_LE at ECNT 55.
      issue_at(1'b1, 55, t1);
      drain();

      // Write sampled at ECNT 0; stray TSn during ACTIVE and TERM is ignored.
      issue_at(1'b0, 0, t1);
      wait_cyc(t1 - 20);
      pulse_ts(1'b1);
      wait_cyc(t1);
      pulse_ts(1'b1);
      drain();

      // TSn without CIA space does nothing.
      repeat (5) next_cyc();
      pulse_ts(1'b0);
      repeat (120) next_cyc();

      // Back-to-back reads: second request as soon as TAn returns high.
      issue_at(1'b1, 10, t1);
      wait_cyc(t1 + 1);
      issue_now(1'b1, t2);
      chk("b2b_spacing", t2 - t1, 112);
      drain();

      // Reset held 3 clocks mid-ACTIVE: access aborted, no TAn afterwards.
      issue_at(1'b1, 20, t1);
      wait_cyc(t1 - 30);
      rst = 1'b1;
      repeat (3) next_cyc();
      rst = 1'b0;
      repeat (150) next_cyc();

      // Normal access after reset recovery.
      issue_at(1'b0, 40, t1);
      drain();
      repeat (5) next_cyc();

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
